// File: rtl/full_adder_bist_pkg.sv
// Shared definitions for the full-adder built-in self-test controller.
// Holds the FSM encoding and the sizing constants used by the controller.
package full_adder_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int NUM_VECTORS = 8;
  localparam int VEC_W       = 3;
  localparam int ERR_W       = 4;
  localparam int SETTLE_W    = 4;

endpackage

// File: rtl/full_adder_bist_ref.sv
// Golden full-adder model used by the BIST controller to judge the device
// under test; purely combinational.
module full_adder_bist_ref (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic exp_out,
  output logic exp_cy
);

  assign exp_out = a ^ b ^ c;
  assign exp_cy  = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/full_adder_bist.sv
// Exhaustive BIST controller for an external full adder: walks all eight
// input vectors, compares against the golden model and reports the result.
module full_adder_bist
  import full_adder_bist_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic             dut_A,
  output logic             dut_B,
  output logic             dut_C,
  input  logic             dut_out,
  input  logic             dut_cy,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic             fail_valid,
  output logic [VEC_W-1:0] first_fail_vec
);

  localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE - 1);
  localparam logic [VEC_W-1:0]    LAST_VEC    = VEC_W'(NUM_VECTORS - 1);

  state_t              state_q, state_d;
  logic [VEC_W-1:0]    vec_q, vec_d;
  logic [SETTLE_W-1:0] settle_q, settle_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic                fail_valid_q, fail_valid_d;
  logic [VEC_W-1:0]    first_fail_q, first_fail_d;
  logic [VEC_W-1:0]    drive_q, drive_d;

  logic exp_out, exp_cy;
  logic mismatch;

  full_adder_bist_ref u_ref (
    .a       (vec_q[0]),
    .b       (vec_q[1]),
    .c       (vec_q[2]),
    .exp_out (exp_out),
    .exp_cy  (exp_cy)
  );

  // Both bits wrong still counts as a single failing vector.
  assign mismatch = (dut_out != exp_out) || (dut_cy != exp_cy);

  always_comb begin
    // NOTE: every signal gets its hold value first so no path infers a latch.
    state_d      = state_q;
    vec_d        = vec_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    first_fail_d = first_fail_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d      = APPLY;
          vec_d        = '0;
          settle_d     = '0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          first_fail_d = '0;
        end
      end
      APPLY: begin
        if (settle_q == SETTLE_LAST) begin
          state_d  = CHECK;
          settle_d = '0;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          err_d = err_q + 1'b1;
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            first_fail_d = vec_q;
          end
        end
        if (vec_q == LAST_VEC) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + 1'b1;
          state_d = APPLY;
        end
      end
      default: state_d = IDLE;
    endcase

    // Stimulus follows the vector only while a run is active.
    drive_d = ((state_d == APPLY) || (state_d == CHECK)) ? vec_d : '0;
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      settle_q     <= '0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      first_fail_q <= '0;
      drive_q      <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      first_fail_q <= first_fail_d;
      drive_q      <= drive_d;
    end
  end

  assign dut_A          = drive_q[0];
  assign dut_B          = drive_q[1];
  assign dut_C          = drive_q[2];
  assign busy           = (state_q == APPLY) || (state_q == CHECK);
  assign done           = (state_q == DONE);
  assign pass           = done && (err_q == '0);
  assign err_count      = err_q;
  assign fail_valid     = fail_valid_q;
  assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_full_adder_bist.sv
// Self-checking bench: two BIST instances (SETTLE=1 and SETTLE=3) each drive a
// behavioural full adder with selectable faults; results go through a scoreboard.
module tb_full_adder_bist;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start1 = 1'b0, start3 = 1'b0;
  int   fault1 = 0, fault3 = 0;

  logic a1, b1, c1, out1, cy1, busy1, done1, pass1, fv1;
  logic [3:0] err1;
  logic [2:0] ffv1;
  logic a3, b3, c3, out3, cy3, busy3, done3, pass3, fv3;
  logic [3:0] err3;
  logic [2:0] ffv3;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int err;
    int ffv;
    int fv;
    int pass;
    int lat;
  } exp_t;

  typedef struct {
    logic       busy, done, pass, fv;
    logic [3:0] err;
    logic [2:0] ffv, vec;
  } obs_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  // Behavioural adders under test: 0 = good, 1 = carry stuck at 0, 2 = sum inverted.
  always_comb begin
    out1 = a1 ^ b1 ^ c1 ^ (fault1 == 2);
    cy1  = (fault1 == 1) ? 1'b0 : ((a1 & b1) | (a1 & c1) | (b1 & c1));
    out3 = a3 ^ b3 ^ c3 ^ (fault3 == 2);
    cy3  = (fault3 == 1) ? 1'b0 : ((a3 & b3) | (a3 & c3) | (b3 & c3));
  end

  full_adder_bist #(.SETTLE(1)) u_bist1 (
    .clk(clk), .rst(rst), .start(start1),
    .dut_A(a1), .dut_B(b1), .dut_C(c1), .dut_out(out1), .dut_cy(cy1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_valid(fv1), .first_fail_vec(ffv1)
  );

  full_adder_bist #(.SETTLE(3)) u_bist3 (
    .clk(clk), .rst(rst), .start(start3),
    .dut_A(a3), .dut_B(b3), .dut_C(c3), .dut_out(out3), .dut_cy(cy3),
    .busy(busy3), .done(done3), .pass(pass3), .err_count(err3),
    .fail_valid(fv3), .first_fail_vec(ffv3)
  );

  task automatic check(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic obs_t sample_obs(input int inst);
    obs_t o;
    if (inst == 0) begin
      o.busy = busy1; o.done = done1; o.pass = pass1; o.fv = fv1;
      o.err = err1; o.ffv = ffv1; o.vec = {c1, b1, a1};
    end else begin
      o.busy = busy3; o.done = done3; o.pass = pass3; o.fv = fv3;
      o.err = err3; o.ffv = ffv3; o.vec = {c3, b3, a3};
    end
    return o;
  endfunction

  task automatic set_start(input int inst, input logic v);
    if (inst == 0) start1 = v;
    else start3 = v;
  endtask

  // Expected outcome from arithmetic on bit counts, independent of gate structure.
  function automatic exp_t model(input int fault, input int settle);
    exp_t e;
    int n, good_s, good_c, got_s, got_c;
    e.err = 0; e.ffv = 0; e.fv = 0;
    for (int v = 0; v < 8; v++) begin
      n = (v & 1) + ((v >> 1) & 1) + ((v >> 2) & 1);
      good_s = n % 2;
      good_c = (n >= 2) ? 1 : 0;
      got_s  = (fault == 2) ? 1 - good_s : good_s;
      got_c  = (fault == 1) ? 0 : good_c;
      if (got_s != good_s || got_c != good_c) begin
        if (e.fv == 0) begin
          e.fv  = 1;
          e.ffv = v;
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) ? 1 : 0;
    e.lat  = 8 * (settle + 1);
    return e;
  endfunction

  task automatic check_idle(input int inst, input string tag);
    obs_t o;
    o = sample_obs(inst);
    check({tag, "_busy"}, int'(o.busy), 0);
    check({tag, "_done"}, int'(o.done), 0);
    check({tag, "_pass"}, int'(o.pass), 0);
    check({tag, "_err"},  int'(o.err),  0);
    check({tag, "_fv"},   int'(o.fv),   0);
    check({tag, "_ffv"},  int'(o.ffv),  0);
    check({tag, "_vec"},  int'(o.vec),  0);
  endtask

  // Launch one run, optionally re-pulsing start mid-run, and score the result.
  task automatic run(input int inst, input int fault, input int restart_at, input string tag);
    exp_t e;
    obs_t o;
    int   settle, cycles, busy_cnt, vec_bad;
    settle = (inst == 0) ? 1 : 3;
    if (inst == 0) fault1 = fault;
    else fault3 = fault;
    sb.push_back(model(fault, settle));
    set_start(inst, 1'b1);
    @(negedge clk);
    set_start(inst, 1'b0);
    cycles = 0; busy_cnt = 0; vec_bad = 0;
    while (1) begin
      o = sample_obs(inst);
      if (o.done || cycles >= 400) break;
      if (o.busy) busy_cnt++;
      if (int'(o.vec) != cycles / (settle + 1)) vec_bad++;
      if (cycles == restart_at) set_start(inst, 1'b1);
      @(negedge clk);
      set_start(inst, 1'b0);
      cycles++;
    end
    e = sb.pop_front();
    check({tag, "_latency"}, cycles, e.lat);
    check({tag, "_busy_cycles"}, busy_cnt, e.lat);
    check({tag, "_vec_seq_errors"}, vec_bad, 0);
    check({tag, "_done"}, int'(o.done), 1);
    check({tag, "_pass"}, int'(o.pass), e.pass);
    check({tag, "_err"}, int'(o.err), e.err);
    check({tag, "_fv"}, int'(o.fv), e.fv);
    check({tag, "_ffv"}, int'(o.ffv), e.ffv);
    repeat (5) @(negedge clk);
    o = sample_obs(inst);
    check({tag, "_hold_done"}, int'(o.done), 1);
    check({tag, "_hold_busy"}, int'(o.busy), 0);
    check({tag, "_hold_err"}, int'(o.err), e.err);
    check({tag, "_hold_ffv"}, int'(o.ffv), e.ffv);
    check({tag, "_hold_vec"}, int'(o.vec), 0);
  endtask

  initial begin
    int waited;
    obs_t o;

    repeat (2) @(negedge clk);
    rst = 1'b0;
    check_idle(0, "reset1");
    check_idle(1, "reset3");

    run(0, 0, -1, "good");
    run(0, 1, -1, "cy_stuck0");
    run(0, 2, -1, "out_inv");
    run(0, 0, 4, "restart_ignored");

    // Abort mid-run with a faulty adder so partial errors exist before reset.
    fault1 = 2;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    waited = 0;
    while ({c1, b1, a1} != 3'd4 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check("abort_reached_vec4", int'({c1, b1, a1}), 4);
    check("abort_partial_err", int'(err1), 4);
    rst = 1'b1;
    start1 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start1 = 1'b0;
    check_idle(0, "abort");
    @(negedge clk);
    check("abort_stays_idle", int'(busy1), 0);
    run(0, 0, -1, "after_abort");

    run(1, 0, -1, "settle3");
    start3 = 1'b1;
    @(negedge clk);
    start3 = 1'b0;
    o = sample_obs(1);
    check("restart3_done_cleared", int'(o.done), 0);
    check("restart3_busy", int'(o.busy), 1);
    check("restart3_err_cleared", int'(o.err), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
